// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer, count and flag controller for a FIFO built on an external dual-port RAM
// with one-cycle read latency. Define FIFO_CTRL_ERR_EN to add sticky overflow/underflow outputs.
module fifo_ctrl #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              pop,
    output logic              full,
    output logic              empty,
    output logic [ADDR_W:0]   count,
    output logic              rd_valid,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_waddr,
    output logic [DATA_W-1:0] ram_din,
    output logic              ram_re,
    output logic [ADDR_W-1:0] ram_raddr
`ifdef FIFO_CTRL_ERR_EN
    ,
    output logic              overflow,
    output logic              underflow
`endif
);

    localparam logic [ADDR_W:0] FULL_COUNT = {1'b1, {ADDR_W{1'b0}}};

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;
    logic [ADDR_W:0]   count_next;

    // Acceptance uses the registered flags, so a full FIFO still takes a pop and an
    // empty FIFO still takes a push when both are requested together.
    // NOTE: count_next gets a default before any branch, so no latch is inferred.
    always_comb begin
        push_ok    = push && !full  && !reset;
        pop_ok     = pop  && !empty && !reset;
        count_next = count;
        if (push_ok && !pop_ok) begin
            count_next = count + (ADDR_W+1)'(1);
        end else if (pop_ok && !push_ok) begin
            count_next = count - (ADDR_W+1)'(1);
        end
    end

    assign ram_we    = push_ok;
    assign ram_waddr = wr_ptr;
    assign ram_din   = wr_data;
    assign ram_re    = pop_ok;
    assign ram_raddr = rd_ptr;

    // NOTE: non-blocking assignments so every register updates from start-of-cycle values.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= 1'b0;
            empty    <= 1'b1;
            rd_valid <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            count    <= count_next;
            full     <= (count_next == FULL_COUNT);
            empty    <= (count_next == '0);
            rd_valid <= pop_ok;
        end
    end

`ifdef FIFO_CTRL_ERR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (push && full) begin
                overflow <= 1'b1;
            end
            if (pop && empty) begin
                underflow <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: vector table, directed corner sequences and randomized traffic against a
// queue-based FIFO model; a behavioural RAM with one-cycle read latency sits beside the DUT.
module tb_fifo_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 16;

    logic              clk = 1'b0;
    logic              reset;
    logic              push;
    logic              pop;
    logic [DATA_W-1:0] wr_data;
    logic              full;
    logic              empty;
    logic [ADDR_W:0]   count;
    logic              rd_valid;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_din;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_raddr;
`ifdef FIFO_CTRL_ERR_EN
    logic              overflow;
    logic              underflow;
`endif

    fifo_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .wr_data   (wr_data),
        .pop       (pop),
        .full      (full),
        .empty     (empty),
        .count     (count),
        .rd_valid  (rd_valid),
        .ram_we    (ram_we),
        .ram_waddr (ram_waddr),
        .ram_din   (ram_din),
        .ram_re    (ram_re),
        .ram_raddr (ram_raddr)
`ifdef FIFO_CTRL_ERR_EN
        ,
        .overflow  (overflow),
        .underflow (underflow)
`endif
    );

    always #5 clk = ~clk;

    // External RAM: registered read, one cycle latency.
    logic [DATA_W-1:0] ram_mem [DEPTH];
    logic [DATA_W-1:0] ram_dout;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_waddr] <= ram_din;
        if (ram_re) ram_dout <= ram_mem[ram_raddr];
    end

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: contents as a queue, pointers as accepted-operation totals mod DEPTH.
    logic [DATA_W-1:0] model_q [$];
    int   wp;
    int   rp;
    logic exp_ovf;
    logic exp_unf;

    task automatic cycle(input logic p, input logic q, input logic [DATA_W-1:0] d);
        logic              we_e;
        logic              re_e;
        logic [DATA_W-1:0] popped;
        push = p; pop = q; wr_data = d;
        #1;
        we_e = p && (model_q.size() < DEPTH);
        re_e = q && (model_q.size() != 0);
        check("ram_we", ram_we, we_e);
        check("ram_re", ram_re, re_e);
        if (we_e) begin
            check("ram_waddr", ram_waddr, wp);
            check("ram_din", ram_din, d);
        end
        if (re_e) check("ram_raddr", ram_raddr, rp);
        if (p && model_q.size() == DEPTH) exp_ovf = 1'b1;
        if (q && model_q.size() == 0) exp_unf = 1'b1;
        @(posedge clk);
        popped = '0;
        if (re_e) begin
            popped = model_q.pop_front();
            rp = (rp + 1) % DEPTH;
        end
        if (we_e) begin
            model_q.push_back(d);
            wp = (wp + 1) % DEPTH;
        end
        #1;
        check("count", count, model_q.size());
        check("full", full, model_q.size() == DEPTH);
        check("empty", empty, model_q.size() == 0);
        check("rd_valid", rd_valid, re_e);
        if (re_e) check("dout", ram_dout, popped);
`ifdef FIFO_CTRL_ERR_EN
        check("overflow", overflow, exp_ovf);
        check("underflow", underflow, exp_unf);
`endif
        @(negedge clk);
    endtask

    task automatic do_reset(input logic p, input logic q);
        reset = 1'b1; push = p; pop = q; wr_data = 8'hA5;
        #1;
        check("rst_ram_we", ram_we, 1'b0);
        check("rst_ram_re", ram_re, 1'b0);
        @(posedge clk);
        #1;
        check("rst_count", count, 0);
        check("rst_empty", empty, 1'b1);
        check("rst_full", full, 1'b0);
        check("rst_rd_valid", rd_valid, 1'b0);
`ifdef FIFO_CTRL_ERR_EN
        check("rst_overflow", overflow, 1'b0);
        check("rst_underflow", underflow, 1'b0);
`endif
        model_q.delete();
        wp = 0; rp = 0; exp_ovf = 1'b0; exp_unf = 1'b0;
        @(negedge clk);
        reset = 1'b0; push = 1'b0; pop = 1'b0;
    endtask

    typedef struct {
        logic              push;
        logic              pop;
        logic [DATA_W-1:0] data;
        logic              we;
        logic              re;
        logic [ADDR_W:0]   cnt;
        logic              full;
        logic              empty;
        logic              rdv;
        logic [DATA_W-1:0] dout;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b1, 1'b0, 8'hA1, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[1] = '{1'b1, 1'b0, 8'hB2, 1'b1, 1'b0, 5'd2, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[2] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'hA1};
        vecs[3] = '{1'b1, 1'b1, 8'hC3, 1'b1, 1'b1, 5'd1, 1'b0, 1'b0, 1'b1, 8'hB2};
        vecs[4] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b1, 5'd0, 1'b0, 1'b1, 1'b1, 8'hC3};
        vecs[5] = '{1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 8'h00};
        vecs[6] = '{1'b1, 1'b1, 8'hD4, 1'b1, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 5'd1, 1'b0, 1'b0, 1'b0, 8'h00};

        reset = 1'b1; push = 1'b0; pop = 1'b0; wr_data = '0;
        wp = 0; rp = 0; exp_ovf = 1'b0; exp_unf = 1'b0;
        @(negedge clk);
        do_reset(1'b0, 1'b0);

        // Idle after reset
        cycle(1'b0, 1'b0, 8'h00);

        // Vector table
        for (int i = 0; i < 8; i++) begin
            push = vecs[i].push; pop = vecs[i].pop; wr_data = vecs[i].data;
            #1;
            check($sformatf("vec%0d_we", i), ram_we, vecs[i].we);
            check($sformatf("vec%0d_re", i), ram_re, vecs[i].re);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_count", i), count, vecs[i].cnt);
            check($sformatf("vec%0d_full", i), full, vecs[i].full);
            check($sformatf("vec%0d_empty", i), empty, vecs[i].empty);
            check($sformatf("vec%0d_rd_valid", i), rd_valid, vecs[i].rdv);
            if (vecs[i].rdv) check($sformatf("vec%0d_dout", i), ram_dout, vecs[i].dout);
            @(negedge clk);
        end
        do_reset(1'b0, 1'b0);

        // Fill to 16, then one push too many, then drain in order
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 1'b0, 8'(8'h10 + i));
        check("fill_full", full, 1'b1);
        cycle(1'b1, 1'b0, 8'hEE);
        check("overfill_count", count, 16);
`ifdef FIFO_CTRL_ERR_EN
        check("overfill_overflow", overflow, 1'b1);
`endif
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'h00);
        check("drain_empty", empty, 1'b1);

        // Pointer wrap: fill 10, pop 10, push 10, then drain
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h30 + i));
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 8'(8'h50 + i));
        check("wrap_count", count, 10);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, 8'h00);

        // Simultaneous push and pop at count 0, 5 and 16
        do_reset(1'b0, 1'b0);
        cycle(1'b1, 1'b1, 8'h61);
        check("pp_at0_count", count, 1);
        for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 8'(8'h62 + i));
        cycle(1'b1, 1'b1, 8'h70);
        check("pp_at5_count", count, 5);
        for (int i = 0; i < 11; i++) cycle(1'b1, 1'b0, 8'(8'h71 + i));
        cycle(1'b1, 1'b1, 8'h7F);
        check("pp_at16_count", count, 15);

        // Reset with count 7 and a read in flight
        do_reset(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, 8'(8'h80 + i));
        cycle(1'b0, 1'b1, 8'h00);
        check("inflight_count", count, 7);
        do_reset(1'b0, 1'b1);

        // Randomized traffic, push-biased then pop-biased, with rare resets
        for (int i = 0; i < 600; i++) begin
            int bias;
            bias = (i < 300) ? 65 : 35;
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end else begin
                cycle(1'($urandom_range(0, 99) < bias), 1'($urandom_range(0, 99) >= bias),
                      8'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 Parameter ADDR_W, default 4: RAM address width; depth = 2**ADDR_W (16 entries).
REQ-002 Parameter DATA_W, default 8: data width of the external dual-port RAM.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port push  input  1: producer requests a write of wr_data this cycle.
REQ-006 Port wr_data  input  DATA_W: write data from the producer.
REQ-007 Port pop  input  1: consumer requests a read this cycle.
REQ-008 Port full  output  1: high when count == 2**ADDR_W.
REQ-009 Port empty  output  1: high when count == 0.
REQ-010 Port count  output  ADDR_W+1: number of stored entries, 0..16.
REQ-011 Port rd_valid  output  1: RAM dout holds the popped word this cycle.
REQ-012 Port ram_we, ram_waddr, ram_din  output  1/ADDR_W/DATA_W: RAM write port (we, we_addr, din).
REQ-013 Port ram_re, ram_raddr  output  1/ADDR_W: RAM read port (re, re_addr); read data is taken from the RAM's dout, not routed through this block.

Function
REQ-014 Push accepted iff push && !full, evaluated on state at the start of the cycle.
REQ-015 Pop accepted iff pop && !empty, evaluated on state at the start of the cycle.
REQ-016 ram_we = accepted push; ram_waddr = wr_ptr; ram_din = wr_data; all combinational.
REQ-017 ram_re = accepted pop; ram_raddr = rd_ptr; both combinational.
REQ-018 wr_ptr increments by 1 on accepted push; rd_ptr increments by 1 on accepted pop; both wrap modulo 2**ADDR_W (15 -> 0).
REQ-019 count: +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-020 full and empty are registered, derived from the next-state count; they never both assert.
REQ-021 rd_valid is registered: it asserts exactly one cycle after an accepted pop (one-cycle RAM read latency) and is otherwise low.
REQ-022 Full with push && pop: the pop is accepted, the push is rejected; count goes 16 -> 15.
REQ-023 Empty with push && pop: the push is accepted, the pop is rejected (no fall-through); count goes 0 -> 1.
REQ-024 Rejected requests change no state and drive ram_we/ram_re low.
REQ-025 Data order is strict first-in first-out across pointer wrap-around.

Reset
REQ-026 When reset is high at a clock edge: wr_ptr, rd_ptr and count = 0, empty = 1, full = 0, rd_valid = 0.
REQ-027 While reset is high, ram_we and ram_re are forced low regardless of push and pop.
REQ-028 Reset mid-operation discards in-flight reads (rd_valid = 0 the next cycle); RAM contents are left untouched but are logically lost.

Configuration
REQ-029 With macro FIFO_CTRL_ERR_EN defined, the block adds outputs overflow and underflow (1 bit each).
REQ-030 overflow sets on push && full; underflow sets on pop && empty.
REQ-031 Both flags are sticky and are cleared only by reset.
REQ-032 Without FIFO_CTRL_ERR_EN, the overflow and underflow ports and their logic do not exist; all other behaviour is identical.

Verification
REQ-033 Reset then idle -> empty = 1, full = 0, count = 0, rd_valid = 0, ram_we = ram_re = 0.
REQ-034 16 pushes of 0x10..0x1F -> ram_waddr 0..15, full = 1 after the 16th; a 17th push -> ram_we = 0, count stays 16 (overflow = 1 if ERR_EN).
REQ-035 16 pops after the fill -> ram_raddr 0..15, rd_valid one cycle after each pop, dout sequence 0x10..0x1F, empty = 1 at the end.
REQ-036 Fill 10, pop 10, push 10 more -> wr_ptr wraps 15 -> 0, read order preserved, count 10.
REQ-037 push && pop at count 0, 5 and 16 -> count becomes 1, 5 and 15 respectively.
REQ-038 Reset asserted with count = 7 and a pop in flight -> next cycle count = 0, empty = 1, rd_valid = 0.
